// File: rtl/decoder_arb4_rr.sv
// Round-robin sequencer sharing one 2x4 decoder among four requesters.
// Registered one-hot grant plus binary index, bounded hold time and a dead cycle between owners.
module decoder_arb4_rr #(
   parameter int MAXHOLD = 8,
   parameter int CW      = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] REQ,
   output logic [3:0] GNT,
   output logic [1:0] GIDX,
   output logic       BUSY,
   output logic       TOUT
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   localparam logic [CW-1:0] HOLD_LAST = CW'(MAXHOLD - 1);

   logic [1:0]    state_reg, state_next;
   logic [3:0]    gnt_reg, gnt_next;
   logic [1:0]    gidx_reg, gidx_next;
   logic [1:0]    last_reg, last_next;
   logic          busy_reg, busy_next;
   logic          tout_reg, tout_next;
   logic [CW-1:0] cnt_reg, cnt_next;

   logic          found;
   logic [1:0]    win;
   logic [1:0]    cand;
   logic [3:0]    win_onehot;

   // Scan starts just past the previous owner, so it ranks lowest next round.
   always_comb begin
      found = 1'b0;
      win   = 2'd0;
      cand  = last_reg;
      for (int k = 1; k <= 4; k++) begin
         cand = last_reg + 2'(k);
         if (!found && REQ[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_onehot
         assign win_onehot[gi] = (win == 2'(gi));
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      gnt_next   = gnt_reg;
      gidx_next  = gidx_reg;
      last_next  = last_reg;
      cnt_next   = cnt_reg;
      tout_next  = 1'b0;
      case (state_reg)
         ST_GRANT: begin
            if (!REQ[gidx_reg]) begin
               // A release on the expiry edge is voluntary, so no timeout pulse.
               state_next = ST_GAP;
               gnt_next   = 4'b0000;
            end else if (cnt_reg == HOLD_LAST) begin
               state_next = ST_GAP;
               gnt_next   = 4'b0000;
               tout_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            if (found) begin
               state_next = ST_GRANT;
               gnt_next   = win_onehot;
               gidx_next  = win;
               last_next  = win;
               cnt_next   = '0;
            end else begin
               state_next = ST_IDLE;
               gnt_next   = 4'b0000;
            end
         end
      endcase
      busy_next = |gnt_next;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= ST_IDLE;
         gnt_reg   <= 4'b0000;
         gidx_reg  <= 2'd0;
         last_reg  <= 2'd3;
         busy_reg  <= 1'b0;
         tout_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         gnt_reg   <= gnt_next;
         gidx_reg  <= gidx_next;
         last_reg  <= last_next;
         busy_reg  <= busy_next;
         tout_reg  <= tout_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign GNT  = gnt_reg;
   assign GIDX = gidx_reg;
   assign BUSY = busy_reg;
   assign TOUT = tout_reg;

endmodule

// File: tb/tb_decoder_arb4_rr.sv
// Bench for decoder_arb4_rr: two instances (MAXHOLD=4 and MAXHOLD=1) on shared stimulus,
// each compared every cycle against an owner/hold-count reference model.
module tb_decoder_arb4_rr;

   logic       CLK;
   logic       RST;
   logic [3:0] REQ;

   logic [3:0] gnt0, gnt1;
   logic [1:0] gidx0, gidx1;
   logic       busy0, busy1, tout0, tout1;

   int checks = 0;
   int errors = 0;

   int own  [2];
   int held [2];
   int last [2];
   int gidx_m [2];
   int tout_m [2];
   int maxh [2] = '{4, 1};

   decoder_arb4_rr #(.MAXHOLD(4), .CW(8)) u0 (
      .CLK(CLK), .RST(RST), .REQ(REQ),
      .GNT(gnt0), .GIDX(gidx0), .BUSY(busy0), .TOUT(tout0)
   );

   decoder_arb4_rr #(.MAXHOLD(1), .CW(4)) u1 (
      .CLK(CLK), .RST(RST), .REQ(REQ),
      .GNT(gnt1), .GIDX(gidx1), .BUSY(busy1), .TOUT(tout1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One clock: advance the model with the inputs present at the edge, then compare.
   task automatic step();
      int c;
      logic [3:0] eg;
      logic [3:0] og, ob, ot, oi;
      @(posedge CLK);
      for (int i = 0; i < 2; i++) begin
         if (RST) begin
            own[i] = -1; held[i] = 0; last[i] = 3; gidx_m[i] = 0; tout_m[i] = 0;
         end else begin
            tout_m[i] = 0;
            if (own[i] >= 0) begin
               if (!REQ[own[i]]) begin
                  own[i] = -1;
               end else if (held[i] == maxh[i]) begin
                  own[i] = -1;
                  tout_m[i] = 1;
               end else begin
                  held[i]++;
               end
            end else begin
               for (int k = 1; k <= 4; k++) begin
                  c = (last[i] + k) % 4;
                  if (own[i] < 0 && REQ[c]) begin
                     own[i] = c; held[i] = 1; last[i] = c; gidx_m[i] = c;
                  end
               end
            end
         end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         eg = (own[i] >= 0) ? 4'(1 << own[i]) : 4'b0000;
         og = (i == 0) ? gnt0 : gnt1;
         oi = (i == 0) ? {2'b00, gidx0} : {2'b00, gidx1};
         ob = (i == 0) ? {3'b000, busy0} : {3'b000, busy1};
         ot = (i == 0) ? {3'b000, tout0} : {3'b000, tout1};
         chk($sformatf("u%0d.gnt t=%0t", i, $time), og, eg);
         chk($sformatf("u%0d.gidx t=%0t", i, $time), oi, 4'(gidx_m[i]));
         chk($sformatf("u%0d.busy t=%0t", i, $time), ob, {3'b000, eg != 4'b0000});
         chk($sformatf("u%0d.tout t=%0t", i, $time), ot, 4'(tout_m[i]));
      end
      $display("t=%0t rst=%b req=%b | u0 gnt=%b gidx=%0d tout=%b | u1 gnt=%b gidx=%0d tout=%b",
               $time, RST, REQ, gnt0, gidx0, tout0, gnt1, gidx1, tout1);
   endtask

   task automatic steps(input int n);
      for (int j = 0; j < n; j++) step();
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         own[i] = -1; held[i] = 0; last[i] = 3; gidx_m[i] = 0; tout_m[i] = 0;
      end
      RST = 1'b1;
      REQ = 4'b1111;
      #2;

      // Reset held two cycles with all requests high.
      steps(2);
      chk("reset_gnt", gnt0, 4'b0000);
      chk("reset_gidx", {2'b00, gidx0}, 4'b0000);
      chk("reset_busy_tout", {2'b00, busy0, tout0}, 4'b0000);

      // First grant after reset goes to requester 0.
      RST = 1'b0;
      step();
      chk("first_grant", gnt0, 4'b0001);
      chk("first_gidx", {2'b00, gidx0}, 4'b0000);
      REQ = 4'b0000;
      steps(3);

      // Single requester, voluntary release after three cycles.
      REQ = 4'b0100;
      step();
      chk("single_gnt", gnt0, 4'b0100);
      chk("single_gidx", {2'b00, gidx0}, 4'b0010);
      steps(2);
      REQ = 4'b0000;
      step();
      chk("release_gap", {gnt0[3:1], tout0}, 4'b0000);
      steps(2);

      // Sole requester timing out repeatedly.
      REQ = 4'b0010;
      steps(4);
      step();
      chk("timeout_pulse", {3'b000, tout0}, 4'b0001);
      chk("timeout_gap", gnt0, 4'b0000);
      step();
      chk("regrant_sole", gnt0, 4'b0010);
      steps(6);
      REQ = 4'b0000;
      steps(2);

      // Full contention: rotation order across both instances.
      REQ = 4'b1111;
      steps(24);
      REQ = 4'b0000;
      steps(2);

      // Priority rotation after requester 2.
      REQ = 4'b0100;
      steps(2);
      REQ = 4'b0000;
      step();
      REQ = 4'b1011;
      step();
      chk("rotate_to_3", {2'b00, gidx0}, 4'b0011);
      REQ = 4'b0011;
      steps(9);
      REQ = 4'b0000;
      steps(2);

      // Reset in the middle of a grant to requester 3.
      REQ = 4'b1000;
      steps(2);
      RST = 1'b1;
      step();
      chk("rst_mid_grant", gnt0, 4'b0000);
      RST = 1'b0;
      REQ = 4'b1001;
      step();
      chk("after_rst_grant0", gnt0, 4'b0001);
      // Drop on the expiry edge is a voluntary release.
      steps(3);
      REQ = 4'b1000;
      step();
      chk("drop_on_expiry_tout", {3'b000, tout0}, 4'b0000);
      chk("drop_on_expiry_gnt", gnt0, 4'b0000);
      REQ = 4'b0000;
      steps(2);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 600; n++) begin
         REQ = 4'($urandom_range(0, 15));
         RST = ($urandom_range(0, 63) == 0);
         step();
      end
      RST = 1'b0;
      REQ = 4'b0000;
      steps(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
